// File: rtl/anim_pkg.sv
// Shared animation constants: state encoding plus sprite-sheet base index and frame count per state.
// Latency: none (declarations only).
// Backpressure: none.
package anim_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    PUNCH = 3'd2,
    KICK  = 3'd3,
    HURT  = 3'd4,
    KO    = 3'd5
  } anim_state_t;

  // Sprite-sheet layout; the GPU animation_offset lookup uses these same values.
  localparam logic [9:0] IDLE_BASE    = 10'd0;
  localparam logic [9:0] IDLE_FRAMES  = 10'd4;
  localparam logic [9:0] WALK_BASE    = 10'd4;
  localparam logic [9:0] WALK_FRAMES  = 10'd6;
  localparam logic [9:0] PUNCH_BASE   = 10'd10;
  localparam logic [9:0] PUNCH_FRAMES = 10'd3;
  localparam logic [9:0] KICK_BASE    = 10'd13;
  localparam logic [9:0] KICK_FRAMES  = 10'd4;
  localparam logic [9:0] HURT_BASE    = 10'd17;
  localparam logic [9:0] HURT_FRAMES  = 10'd2;
  localparam logic [9:0] KO_BASE      = 10'd19;
  localparam logic [9:0] KO_FRAMES    = 10'd3;

  function automatic logic [9:0] anim_base(input anim_state_t s);
    case (s)
      WALK:    return WALK_BASE;
      PUNCH:   return PUNCH_BASE;
      KICK:    return KICK_BASE;
      HURT:    return HURT_BASE;
      KO:      return KO_BASE;
      default: return IDLE_BASE;
    endcase
  endfunction

  function automatic logic [9:0] anim_frames(input anim_state_t s);
    case (s)
      WALK:    return WALK_FRAMES;
      PUNCH:   return PUNCH_FRAMES;
      KICK:    return KICK_FRAMES;
      HURT:    return HURT_FRAMES;
      KO:      return KO_FRAMES;
      default: return IDLE_FRAMES;
    endcase
  endfunction

endpackage

// File: rtl/player_animator_if.sv
// Gameplay-side bundle of one player's animator: requests in, animation index and status out.
// Latency: none (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface player_animator_if;
  import anim_pkg::*;

  logic       frame_clk;
  logic [9:0] health;
  logic       hurt_pulse;
  logic       punch_req;
  logic       kick_req;
  logic       move_req;
  logic [9:0] animation;
  logic       busy;
  logic       hit_active;
  logic       action_done;

  // Game logic / video side.
  modport master (
    output frame_clk, health, hurt_pulse, punch_req, kick_req, move_req,
    input  animation, busy, hit_active, action_done
  );

  // Animator side.
  modport slave (
    input  frame_clk, health, hurt_pulse, punch_req, kick_req, move_req,
    output animation, busy, hit_active, action_done
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle tick on each rising edge of the vsync level.
// Latency: tick is high in the second Clk after frame_clk is first sampled high.
// Backpressure: none.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_frame_clk,
  output logic o_tick
);

  logic r_frame_d;
  logic r_tick;

  // Delay the vsync level and register its rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frame_d <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_frame_d <= i_frame_clk;
      r_tick    <= i_frame_clk & ~r_frame_d;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/player_animator.sv
// Per-player animation sequencer: gameplay requests -> sprite index, advanced per video frame.
// Latency: request to animation change within one video frame plus two Clk.
// Backpressure: none; requests are sampled on ticks, hurt pulses are latched until consumed.
module player_animator
  import anim_pkg::*;
#(
  parameter int TICKS_PER_FRAME = 6,
  parameter int PUNCH_HIT_FRAME = 1,
  parameter int KICK_HIT_FRAME  = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  player_animator_if.slave  bus
);

  localparam int TCNT_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICKS_PER_FRAME - 1);

  logic              w_tick;
  anim_state_t       r_state;
  logic [9:0]        r_frame;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_hurt_pend;
  logic [9:0]        r_anim;
  logic              r_busy;
  logic              r_hit;
  logic              r_done;

  anim_state_t       w_state;
  logic [9:0]        w_frame;
  logic [TCNT_W-1:0] w_tcnt;
  logic              w_adv;
  logic              w_last;
  logic              w_restart;
  logic              w_done;
  logic              w_consume;
  logic              w_hit;

  frame_tick_gen u_tick (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .i_frame_clk (bus.frame_clk),
    .o_tick      (w_tick)
  );

  // Next state/frame for the coming tick, in transition-priority order.
  always_comb begin
    w_adv     = (r_tcnt == TCNT_LAST);
    w_last    = (r_frame == anim_frames(r_state) - 10'd1);
    w_state   = r_state;
    w_frame   = r_frame;
    w_tcnt    = w_adv ? '0 : r_tcnt + TCNT_W'(1);
    w_restart = 1'b0;
    w_done    = 1'b0;
    w_consume = 1'b0;
    if (r_state == KO) begin
      // Only reset leaves KO; the last frame is held.
      if (w_adv && !w_last) w_frame = r_frame + 10'd1;
    end else if (bus.health == 10'd0) begin
      w_state   = KO;
      w_restart = 1'b1;
    end else if (r_hurt_pend) begin
      // Also restarts HURT when already hurt.
      w_state   = HURT;
      w_restart = 1'b1;
      w_consume = 1'b1;
    end else if (r_state inside {PUNCH, KICK, HURT}) begin
      if (w_adv) begin
        if (w_last) begin
          w_state   = bus.move_req ? WALK : IDLE;
          w_restart = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_frame = r_frame + 10'd1;
        end
      end
    end else begin
      if (bus.punch_req)     w_state = PUNCH;
      else if (bus.kick_req) w_state = KICK;
      else if (bus.move_req) w_state = WALK;
      else                   w_state = IDLE;
      if (w_state != r_state) w_restart = 1'b1;
      else if (w_adv)         w_frame = w_last ? 10'd0 : r_frame + 10'd1;
    end
    if (w_restart) begin
      w_frame = 10'd0;
      w_tcnt  = '0;
    end
    w_hit = ((w_state == PUNCH) && (w_frame == 10'(PUNCH_HIT_FRAME))) ||
            ((w_state == KICK)  && (w_frame == 10'(KICK_HIT_FRAME)));
  end

  // Sequencer state and registered outputs; everything but the hurt latch moves only on tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_frame     <= 10'd0;
      r_tcnt      <= '0;
      r_hurt_pend <= 1'b0;
      r_anim      <= 10'd0;
      r_busy      <= 1'b0;
      r_hit       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_hurt_pend <= bus.hurt_pulse | (r_hurt_pend & ~(w_tick & w_consume));
      if (w_tick) begin
        r_state <= w_state;
        r_frame <= w_frame;
        r_tcnt  <= w_tcnt;
        r_anim  <= anim_base(w_state) + w_frame;
        r_busy  <= (w_state inside {PUNCH, KICK, HURT, KO});
        r_hit   <= w_hit;
        r_done  <= w_done;
      end
    end
  end

  assign bus.animation   = r_anim;
  assign bus.busy        = r_busy;
  assign bus.hit_active  = r_hit;
  assign bus.action_done = r_done;

endmodule
